// File: rtl/segmented_counter.sv
// segmented_counter: run-time partitionable bank of GRANULARITY-bit counter segments.
// Define SEGCNT_LOAD_EN to make command 11 load the group from load_data_in; otherwise 11 holds.
module segmented_counter #(
    parameter int GRANULARITY  = 4,
    parameter int NUM_SEGMENTS = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [2*NUM_SEGMENTS-1:0]           seg_cmd_in,
    input  logic [GRANULARITY*NUM_SEGMENTS-1:0] load_data_in,
    input  logic                                cfg_we_in,
    input  logic [NUM_SEGMENTS-2:0]             link_cfg_in,
    output logic [NUM_SEGMENTS-2:0]             link_cfg_out,
    output logic [GRANULARITY*NUM_SEGMENTS-1:0] data_out,
    output logic [NUM_SEGMENTS-1:0]             wrap_out
);
    localparam int G = GRANULARITY;
    localparam int N = NUM_SEGMENTS;
    localparam int W = G * N;

    logic [N-2:0] link;
    logic [W-1:0] data, data_nxt;
    logic [N-1:0] wrap, wrap_nxt;
    logic [N-1:0] lnk_lo, lnk_up, ones;

    // lnk_lo[i]: segment i joined to the one below; lnk_up[i]: joined to the one above
    assign lnk_lo = {link, 1'b0};
    assign lnk_up = {1'b0, link};

`ifndef SEGCNT_LOAD_EN
    logic unused_load;
    assign unused_load = ^load_data_in;
`endif

    always_comb begin
        logic [1:0]   run_cmd;
        logic         carry;
        logic         run_ones;
        logic [G-1:0] seg;
        logic [G-1:0] ld;
        run_cmd  = 2'b10;
        carry    = 1'b0;
        run_ones = 1'b1;
        seg      = '0;
        ld       = '0;
        data_nxt = data;
        wrap_nxt = '0;
        ones     = '0;
        // ones[i]: segment i and every linked segment above it are all-ones
        for (int i = N - 1; i >= 0; i--) begin
            run_ones = (lnk_up[i] ? run_ones : 1'b1) & (&data[G*i +: G]);
            ones[i]  = run_ones;
        end
        for (int i = 0; i < N; i++) begin
            seg     = data[G*i +: G];
            run_cmd = lnk_lo[i] ? run_cmd : seg_cmd_in[2*i +: 2];
            carry   = lnk_lo[i] ? carry : (run_cmd == 2'b01);
`ifdef SEGCNT_LOAD_EN
            ld = load_data_in[G*i +: G];
`else
            ld = seg;
`endif
            wrap_nxt[i] = !lnk_lo[i] && (run_cmd == 2'b01) && ones[i];
            data_nxt[G*i +: G] = (run_cmd == 2'b00) ? '0 :
                                 (run_cmd == 2'b01) ? seg + G'(carry) :
                                 (run_cmd == 2'b11) ? ld : seg;
            carry = carry & (&seg);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
            link <= '0;
            wrap <= '0;
        end else begin
            data <= data_nxt;
            wrap <= wrap_nxt;
            if (cfg_we_in) link <= link_cfg_in;
        end
    end

    assign data_out     = data;
    assign link_cfg_out = link;
    assign wrap_out     = wrap;
endmodule

// File: tb/tb_segmented_counter.sv
// tb_segmented_counter: scoreboard bench; a group-level arithmetic model predicts each edge.
module tb_segmented_counter;
    localparam int G = 4;
    localparam int N = 4;
    localparam int W = G * N;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [2*N-1:0] seg_cmd_in = '0;
    logic [W-1:0]   load_data_in = '0;
    logic           cfg_we_in = 1'b0;
    logic [N-2:0]   link_cfg_in = '0;
    logic [N-2:0]   link_cfg_out;
    logic [W-1:0]   data_out;
    logic [N-1:0]   wrap_out;

    typedef struct packed {
        logic [W-1:0] d;
        logic [N-2:0] l;
        logic [N-1:0] w;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] m_d = '0;
    logic [N-2:0] m_l = '0;
    logic [N-1:0] m_w = '0;
    int           checks = 0;
    int           failures = 0;

    segmented_counter #(.GRANULARITY(G), .NUM_SEGMENTS(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .seg_cmd_in   (seg_cmd_in),
        .load_data_in (load_data_in),
        .cfg_we_in    (cfg_we_in),
        .link_cfg_in  (link_cfg_in),
        .link_cfg_out (link_cfg_out),
        .data_out     (data_out),
        .wrap_out     (wrap_out)
    );

    always #5 clk = ~clk;

    // Drive one edge, predict its result from whole-group integer values, push it, then clock.
    task automatic cycle(input logic r, input logic [2*N-1:0] c, input logic [W-1:0] ld,
                         input logic we, input logic [N-2:0] cfg);
        logic [W-1:0]  nd;
        logic [N-1:0]  nw;
        logic [63:0]   v, mask;
        int            hd, top;
        rst = r; seg_cmd_in = c; load_data_in = ld; cfg_we_in = we; link_cfg_in = cfg;
        nd = m_d; nw = '0; hd = 0;
        while (hd < N) begin
            top = hd;
            while (top < N - 1 && m_l[top]) top++;
            mask = (64'd1 << ((top - hd + 1) * G)) - 64'd1;
            v = (64'(m_d) >> (hd * G)) & mask;
            case (c[2*hd +: 2])
                2'b00: v = '0;
                2'b01: begin nw[hd] = (v == mask); v = (v + 64'd1) & mask; end
`ifdef SEGCNT_LOAD_EN
                2'b11: v = (64'(ld) >> (hd * G)) & mask;
`endif
                default: ;
            endcase
            nd = W'((64'(nd) & ~(mask << (hd * G))) | (v << (hd * G)));
            hd = top + 1;
        end
        if (r) begin m_d = '0; m_l = '0; m_w = '0; end
        else begin m_d = nd; m_w = nw; if (we) m_l = cfg; end
        q.push_back({m_d, m_l, m_w});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        cycle(1'b1, 8'b01010101, 16'hFFFF, 1'b1, 3'b111);
        e = q.pop_front(); checks++;
        if ({data_out, link_cfg_out, wrap_out} !== e) begin
            failures++;
            $display("FAIL reset_sb got d=%h l=%b w=%b exp d=%h l=%b w=%b", data_out, link_cfg_out, wrap_out, e.d, e.l, e.w);
        end
        checks++;
        if (data_out !== 16'h0000 || link_cfg_out !== 3'b000 || wrap_out !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state got d=%h l=%b w=%b exp d=0000 l=000 w=0000", data_out, link_cfg_out, wrap_out);
        end
    endtask

    task automatic test_independent_wrap();
        exp_t e;
        for (int k = 0; k < 17; k++) begin
            cycle(1'b0, (k < 16) ? 8'b10101001 : 8'b10101010, '0, 1'b0, '0);
            e = q.pop_front(); checks++;
            if ({data_out, link_cfg_out, wrap_out} !== e) begin
                failures++;
                $display("FAIL indep_wrap k=%0d got d=%h l=%b w=%b exp d=%h l=%b w=%b", k, data_out, link_cfg_out, wrap_out, e.d, e.l, e.w);
            end
            if (k == 15) begin
                checks++;
                if (data_out !== 16'h0000 || wrap_out !== 4'b0001) begin
                    failures++;
                    $display("FAIL indep_wrap_pulse got d=%h w=%b exp d=0000 w=0001", data_out, wrap_out);
                end
            end
        end
        checks++;
        if (wrap_out !== 4'b0000) begin
            failures++;
            $display("FAIL indep_wrap_single got w=%b exp w=0000", wrap_out);
        end
    endtask

    task automatic test_linked_carry();
        exp_t e;
        for (int k = 0; k < 17; k++) begin
            if (k == 0) cycle(1'b0, 8'b10101010, '0, 1'b1, 3'b001);
            else        cycle(1'b0, 8'b10100001, '0, 1'b0, '0);
            e = q.pop_front(); checks++;
            if ({data_out, link_cfg_out, wrap_out} !== e) begin
                failures++;
                $display("FAIL linked_carry k=%0d got d=%h l=%b w=%b exp d=%h l=%b w=%b", k, data_out, link_cfg_out, wrap_out, e.d, e.l, e.w);
            end
        end
        checks++;
        if (data_out[7:0] !== 8'h10 || wrap_out !== 4'b0000) begin
            failures++;
            $display("FAIL linked_carry_end got d=%h w=%b exp d[7:0]=10 w=0000", data_out, wrap_out);
        end
    endtask

    task automatic test_full_width();
        exp_t e;
        // Fill every segment independently, then merge and wrap the whole group in one step.
        for (int p = 0; p < 2; p++) begin
            cycle(1'b1, '0, '0, 1'b0, '0);
            void'(q.pop_front());
            for (int k = 0; k < 17; k++) begin
                if (k < 15)       cycle(1'b0, 8'b01010101, '0, 1'b0, '0);
                else if (k == 15) cycle(1'b0, 8'b10101010, '0, 1'b1, (p == 0) ? 3'b111 : 3'b011);
                else              cycle(1'b0, (p == 0) ? 8'b00000001 : 8'b01000001, '0, 1'b0, '0);
                e = q.pop_front(); checks++;
                if ({data_out, link_cfg_out, wrap_out} !== e) begin
                    failures++;
                    $display("FAIL full_width p=%0d k=%0d got d=%h l=%b w=%b exp d=%h l=%b w=%b", p, k, data_out, link_cfg_out, wrap_out, e.d, e.l, e.w);
                end
            end
            checks++;
            if (data_out !== 16'h0000 || wrap_out !== ((p == 0) ? 4'b0001 : 4'b1001)) begin
                failures++;
                $display("FAIL full_width_wrap p=%0d got d=%h w=%b exp d=0000 w=%b", p, data_out, wrap_out, (p == 0) ? 4'b0001 : 4'b1001);
            end
        end
        // Count a 12-bit group up through two carry levels; seg3 idles independently.
        for (int k = 0; k < 300; k++) begin
            cycle(1'b0, 8'b10000001, '0, 1'b0, '0);
            e = q.pop_front(); checks++;
            if ({data_out, link_cfg_out, wrap_out} !== e) begin
                failures++;
                $display("FAIL count12 k=%0d got d=%h l=%b w=%b exp d=%h l=%b w=%b", k, data_out, link_cfg_out, wrap_out, e.d, e.l, e.w);
            end
        end
        checks++;
        if (data_out !== 16'h012C) begin
            failures++;
            $display("FAIL count12_end got d=%h exp d=012c", data_out);
        end
    endtask

    task automatic test_cfg_same_edge();
        exp_t e;
        cycle(1'b1, '0, '0, 1'b0, '0);
        void'(q.pop_front());
        for (int k = 0; k < 17; k++) begin
            if (k < 15)       cycle(1'b0, 8'b10101001, '0, 1'b0, '0);
            else if (k == 15) cycle(1'b0, 8'b10101001, '0, 1'b1, 3'b001);
            else              cycle(1'b0, 8'b10101001, '0, 1'b0, '0);
            e = q.pop_front(); checks++;
            if ({data_out, link_cfg_out, wrap_out} !== e) begin
                failures++;
                $display("FAIL cfg_same_edge k=%0d got d=%h l=%b w=%b exp d=%h l=%b w=%b", k, data_out, link_cfg_out, wrap_out, e.d, e.l, e.w);
            end
            if (k == 15) begin
                checks++;
                if (data_out !== 16'h0000 || wrap_out !== 4'b0001 || link_cfg_out !== 3'b001) begin
                    failures++;
                    $display("FAIL cfg_old_used got d=%h l=%b w=%b exp d=0000 l=001 w=0001", data_out, link_cfg_out, wrap_out);
                end
            end
        end
        checks++;
        if (data_out !== 16'h0001 || wrap_out !== 4'b0000) begin
            failures++;
            $display("FAIL cfg_new_used got d=%h w=%b exp d=0001 w=0000", data_out, wrap_out);
        end
    endtask

    task automatic test_load();
        exp_t         e;
        logic [W-1:0] want;
        cycle(1'b1, '0, '0, 1'b0, '0);
        void'(q.pop_front());
        for (int k = 0; k < 5; k++) begin
            if (k == 0)      cycle(1'b0, 8'b10101010, '0, 1'b1, 3'b011);
            else if (k < 4)  cycle(1'b0, 8'b01101001, 16'hABCD, 1'b0, '0);
            else             cycle(1'b0, 8'b10101011, 16'hABCD, 1'b0, '0);
            e = q.pop_front(); checks++;
            if ({data_out, link_cfg_out, wrap_out} !== e) begin
                failures++;
                $display("FAIL load k=%0d got d=%h l=%b w=%b exp d=%h l=%b w=%b", k, data_out, link_cfg_out, wrap_out, e.d, e.l, e.w);
            end
        end
`ifdef SEGCNT_LOAD_EN
        want = 16'h3BCD;
`else
        want = 16'h3003;
`endif
        checks++;
        if (data_out !== want || wrap_out !== 4'b0000) begin
            failures++;
            $display("FAIL load_result got d=%h w=%b exp d=%h w=0000", data_out, wrap_out, want);
        end
    endtask

    initial begin
        test_reset();
        test_independent_wrap();
        test_linked_carry();
        test_full_width();
        test_cfg_same_edge();
        test_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/segmented_counter.md
Name: segmented_counter

Overview:
- Parametrised successor to the single-segment subcounter.
- Holds NUM_SEGMENTS counter segments of GRANULARITY bits each.
- A registered link configuration merges adjacent segments into wider counters (groups); carries ripple within a group in one cycle.
- Serves as the shared-counter resource: one physical bank is partitioned at run time into several independent counters of varying width.

Parameters:
- GRANULARITY, 4, bits per segment (>=1).
- NUM_SEGMENTS, 4, number of segments (>=2).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- seg_cmd_in  input  2*NUM_SEGMENTS  per-segment command, segment i at bits [2i+1:2i]: 00 reset, 01 increment, 10 idle, 11 load.
- load_data_in  input  GRANULARITY*NUM_SEGMENTS  load value, segment i at [G*i+G-1:G*i]; only used when SEGCNT_LOAD_EN is defined.
- cfg_we_in  input  1  write enable for link configuration.
- link_cfg_in  input  NUM_SEGMENTS-1  bit i=1 links segment i+1 above segment i.
- link_cfg_out  output  NUM_SEGMENTS-1  current registered link configuration.
- data_out  output  GRANULARITY*NUM_SEGMENTS  segment values, segment i at [G*i+G-1:G*i].
- wrap_out  output  NUM_SEGMENTS  per-group wrap pulse, reported on the group head bit.

Behaviour:
- Reset: on a posedge with rst=1, data_out=0, link_cfg_out=0 (all segments independent) and wrap_out=0. rst overrides all commands and cfg_we_in.
- Config: on a posedge with cfg_we_in=1, link_cfg_out<=link_cfg_in. The new grouping applies from the next edge. Counts are not altered by a config write.
- Groups and heads:
  - A group is a maximal run of segments joined by link bits.
  - The head is the lowest-index segment of the group; segment j is a head iff j==0 or link_cfg_out[j-1]==0.
  - Only the head's command field is decoded. Non-head command fields are ignored.
- Command decode, applied to the whole group on the posedge:
  - 00: all segments of the group <= 0.
  - 01: group value <= group value + 1, modulo 2^(G*group_size). Carry ripples combinationally from head upward and stops at the group's top segment, never crossing into the next group.
  - 10: hold.
  - 11: see Optional Feature.
- Wrap:
  - wrap_out[head] is registered and high for exactly one cycle after an edge where the group incremented from all-ones to 0.
  - Otherwise wrap_out bits are 0; non-head bits are always 0.
  - Reset, load, or idle of a group clears its wrap bit on that edge.
- Simultaneous events: a config write and commands on the same edge are evaluated with the OLD link configuration. The new configuration governs the following edge.
- Reconfiguration mid-count: segment contents are kept as-is. A newly merged group's value is the concatenation of its segments.
- Width rules: no arithmetic crosses a group boundary. Single-segment groups behave exactly like the legacy subcounter.
- Latency: data_out reflects a command one cycle after the edge it is sampled on (registered output, no combinational path from inputs to outputs).

Optional Feature:
- SEGCNT_LOAD_EN defined: command 11 loads each segment of the group from its own slice of load_data_in. The group's wrap bit is cleared.
- SEGCNT_LOAD_EN undefined: command 11 is treated as idle (hold), load_data_in is unused, and no load logic is synthesised.

Test Plan (GRANULARITY=4, NUM_SEGMENTS=4):
- Reset, then check: rst=1 for 1 cycle -> data_out=16'h0000, link_cfg_out=3'b000, wrap_out=4'b0000.
- Independent wrap: link=000, seg0 cmd=01 for 16 cycles, others idle -> seg0 goes 0..F then 0. wrap_out=4'b0001 for exactly the one cycle after the F->0 edge; seg1 stays 0.
- Linked carry: cfg_we with link=001, then seg0 cmd=01 for 16 cycles -> data_out[7:0]=8'h10. wrap_out=0; seg1's cmd field is ignored even when set to 00.
- Full-width wrap: link=111, seg0 cmd=00 then 01 for 65536 cycles -> data_out returns to 16'h0000 and wrap_out=4'b0001 for one cycle. Repeat with link=011 (12-bit group plus seg3 independent) to confirm the seg3 boundary.
- Config plus command on the same edge: link=000 with seg0=F, then on one edge cfg_we with link=001 and seg0 cmd=01 -> seg0=0, seg1=0, wrap_out[0]=1 (old config used). The next increment gives seg0=1, seg1=0 under the new group.
- Load: with SEGCNT_LOAD_EN, link=011, load_data_in=16'hABCD, seg0 cmd=11 -> data_out[11:0]=12'hBCD and seg3 unchanged. Without the macro, the same stimulus leaves data_out unchanged.
